// File: rtl/frogger_pkg.sv
// Shared definitions for the frog player block: keycodes, FSM states, facing.
package frogger_pkg;

  // USB HID keycodes used for movement
  localparam logic [7:0] KEY_NONE = 8'h00;
  localparam logic [7:0] KEY_W    = 8'h1A;
  localparam logic [7:0] KEY_A    = 8'h04;
  localparam logic [7:0] KEY_S    = 8'h16;
  localparam logic [7:0] KEY_D    = 8'h07;

  // Bit positions inside the one-hot move request
  localparam int REQ_UP    = 0;
  localparam int REQ_DOWN  = 1;
  localparam int REQ_LEFT  = 2;
  localparam int REQ_RIGHT = 3;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_HOP       = 2'd1,
    ST_DYING     = 2'd2,
    ST_GAME_OVER = 2'd3
  } frog_state_t;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } frog_dir_t;

endpackage

// File: rtl/frog_key_decode.sv
// Keycode edge detector: a move key produces a single one-frame request,
// no matter how long it is held. Non-move codes never produce a request.
module frog_key_decode
  import frogger_pkg::*;
(
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic [7:0] keycode,
  output logic [3:0] move_req
);

  logic [7:0] prev_key;

  // Remember last frame's keycode so a held key only counts once
  always_ff @(posedge frame_clk) begin
    if (Reset) prev_key <= KEY_NONE;
    else       prev_key <= keycode;
  end

  // One-hot press pulse: a move code that was not present last frame
  always_comb begin
    move_req = '0;
    if (keycode != prev_key) begin
      move_req[REQ_UP]    = (keycode == KEY_W);
      move_req[REQ_DOWN]  = (keycode == KEY_S);
      move_req[REQ_LEFT]  = (keycode == KEY_A);
      move_req[REQ_RIGHT] = (keycode == KEY_D);
    end
  end

endmodule

// File: rtl/frog_ctrl.sv
// Frog player controller: position, facing, lives and score, one update per
// video frame. Optional feature macro FROGGER_DEATH_ANIM_EN stretches the
// DYING state to DEATH_FRAMES frames; without it DYING lasts a single frame.
module frog_ctrl
  import frogger_pkg::*;
#(
  parameter int START_X      = 300,
  parameter int START_Y      = 440,
  parameter int STEP         = 40,
  parameter int HOP_PX       = 8,
  parameter int FROG_W       = 40,
  parameter int SCREEN_W     = 640,
  parameter int GOAL_Y       = 0,
  parameter int LIVES        = 3,
  parameter int DEATH_FRAMES = 30
) (
  input  logic        frame_clk,
  input  logic        Reset,
  input  logic [7:0]  keycode,
  input  logic        Car_Collision,
  output logic [10:0] Frog_X,
  output logic [10:0] Frog_Y,
  output logic [1:0]  Frog_Dir,
  output logic        Frog_Dying,
  output logic [2:0]  Lives,
  output logic [7:0]  Score,
  output logic        Game_Over
);

  localparam logic [10:0] START_X_L = 11'(START_X);
  localparam logic [10:0] START_Y_L = 11'(START_Y);
  localparam logic [10:0] STEP_L    = 11'(STEP);
  localparam logic [10:0] HOP_L     = 11'(HOP_PX);
  localparam logic [10:0] X_MAX_L   = 11'(SCREEN_W - FROG_W);
  localparam logic [10:0] GOAL_Y_L  = 11'(GOAL_Y);
  localparam logic [5:0]  HOP_LAST  = 6'(STEP / HOP_PX - 1);
  localparam logic [2:0]  LIVES_L   = 3'(LIVES);
`ifdef FROGGER_DEATH_ANIM_EN
  localparam logic [5:0]  DEATH_LAST = 6'(DEATH_FRAMES - 1);
`endif

  frog_state_t state_q, state_d;
  frog_dir_t   dir_q, dir_d;
  frog_dir_t   hop_dir_q, hop_dir_d;
  frog_dir_t   req_dir;
  logic [10:0] x_q, x_d, y_q, y_d;
  logic [10:0] step_x, step_y;
  logic [2:0]  lives_q, lives_d;
  logic [7:0]  score_q, score_d;
  logic [5:0]  hop_cnt_q, hop_cnt_d;
  logic [3:0]  move_req;
  logic        press;
`ifdef FROGGER_DEATH_ANIM_EN
  logic [5:0]  death_cnt_q, death_cnt_d;
`endif

  // Score increment that sticks at the top of the 8-bit range
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Whether one grid hop from (x, y) in direction d stays on the playfield
  function automatic logic target_ok(input frog_dir_t d, input logic [10:0] x,
                                     input logic [10:0] y);
    logic ok;
    unique case (d)
      DIR_UP:    ok = (y >= GOAL_Y_L + STEP_L);
      DIR_DOWN:  ok = (y + STEP_L <= START_Y_L);
      DIR_LEFT:  ok = (x >= STEP_L);
      DIR_RIGHT: ok = (x + STEP_L <= X_MAX_L);
    endcase
    return ok;
  endfunction

  frog_key_decode u_key (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .keycode   (keycode),
    .move_req  (move_req)
  );

  // Translate the one-hot request into a facing direction
  always_comb begin
    press   = |move_req;
    req_dir = DIR_UP;
    if (move_req[REQ_DOWN])       req_dir = DIR_DOWN;
    else if (move_req[REQ_LEFT])  req_dir = DIR_LEFT;
    else if (move_req[REQ_RIGHT]) req_dir = DIR_RIGHT;
  end

  // Position after one animation step of the hop in progress
  always_comb begin
    step_x = x_q;
    step_y = y_q;
    unique case (hop_dir_q)
      DIR_UP:    step_y = y_q - HOP_L;
      DIR_DOWN:  step_y = y_q + HOP_L;
      DIR_LEFT:  step_x = x_q - HOP_L;
      DIR_RIGHT: step_x = x_q + HOP_L;
    endcase
  end

  // Next-state logic: collision first, then hop progress / goal, then presses
  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    dir_d     = dir_q;
    lives_d   = lives_q;
    score_d   = score_q;
    hop_dir_d = hop_dir_q;
    hop_cnt_d = hop_cnt_q;
`ifdef FROGGER_DEATH_ANIM_EN
    death_cnt_d = death_cnt_q;
`endif
    unique case (state_q)
      ST_IDLE, ST_HOP: begin
        if (Car_Collision) begin
          // position stays frozen where the car caught the frog
          lives_d = lives_q - 3'd1;
          state_d = (lives_q == 3'd1) ? ST_GAME_OVER : ST_DYING;
`ifdef FROGGER_DEATH_ANIM_EN
          death_cnt_d = '0;
`endif
        end else if (state_q == ST_IDLE) begin
          if (press) begin
            dir_d = req_dir;
            if (target_ok(req_dir, x_q, y_q)) begin
              state_d   = ST_HOP;
              hop_dir_d = req_dir;
              hop_cnt_d = '0;
            end
          end
        end else begin
          x_d = step_x;
          y_d = step_y;
          if (hop_cnt_q == HOP_LAST) begin
            state_d = ST_IDLE;
            // reaching the goal row scores and respawns in the same frame
            if (step_y == GOAL_Y_L) begin
              score_d = sat_inc(score_q);
              x_d     = START_X_L;
              y_d     = START_Y_L;
            end
          end else begin
            hop_cnt_d = hop_cnt_q + 6'd1;
          end
        end
      end
      ST_DYING: begin
`ifdef FROGGER_DEATH_ANIM_EN
        if (death_cnt_q == DEATH_LAST) begin
          state_d = ST_IDLE;
          x_d     = START_X_L;
          y_d     = START_Y_L;
          dir_d   = DIR_UP;
        end else begin
          death_cnt_d = death_cnt_q + 6'd1;
        end
`else
        state_d = ST_IDLE;
        x_d     = START_X_L;
        y_d     = START_Y_L;
        dir_d   = DIR_UP;
`endif
      end
      ST_GAME_OVER: begin
        lives_d = '0;
      end
    endcase
  end

  // State and datapath registers; reset restores the spawn configuration
  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state_q   <= ST_IDLE;
      x_q       <= START_X_L;
      y_q       <= START_Y_L;
      dir_q     <= DIR_UP;
      lives_q   <= LIVES_L;
      score_q   <= '0;
      hop_dir_q <= DIR_UP;
      hop_cnt_q <= '0;
`ifdef FROGGER_DEATH_ANIM_EN
      death_cnt_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      dir_q     <= dir_d;
      lives_q   <= lives_d;
      score_q   <= score_d;
      hop_dir_q <= hop_dir_d;
      hop_cnt_q <= hop_cnt_d;
`ifdef FROGGER_DEATH_ANIM_EN
      death_cnt_q <= death_cnt_d;
`endif
    end
  end

  assign Frog_X     = x_q;
  assign Frog_Y     = y_q;
  assign Frog_Dir   = dir_q;
  assign Lives      = lives_q;
  assign Score      = score_q;
  assign Frog_Dying = (state_q == ST_DYING);
  assign Game_Over  = (state_q == ST_GAME_OVER);

endmodule

// File: tb/tb_frog_ctrl.sv
// Self-checking bench for frog_ctrl: directed scenarios plus randomized
// keys/collisions/resets, compared every frame against a behavioural model.
module tb_frog_ctrl;

  localparam int START_X  = 300;
  localparam int START_Y  = 440;
  localparam int STEP     = 40;
  localparam int HOP_PX   = 8;
  localparam int FROG_W   = 40;
  localparam int SCREEN_W = 640;
  localparam int GOAL_Y   = 0;
  localparam int LIVES    = 3;
`ifdef FROGGER_DEATH_ANIM_EN
  localparam int DEATH_LEN = 30;
`else
  localparam int DEATH_LEN = 1;
`endif

  localparam logic [7:0] K_NONE = 8'h00;
  localparam logic [7:0] K_W    = 8'h1A;
  localparam logic [7:0] K_A    = 8'h04;
  localparam logic [7:0] K_S    = 8'h16;
  localparam logic [7:0] K_D    = 8'h07;
  localparam logic [7:0] K_SPC  = 8'h2C;

  localparam int PH_IDLE = 0;
  localparam int PH_HOP  = 1;
  localparam int PH_DIE  = 2;
  localparam int PH_OVER = 3;

  logic        frame_clk = 1'b0;
  logic        Reset = 1'b1;
  logic [7:0]  keycode = 8'h00;
  logic        Car_Collision = 1'b0;
  logic [10:0] Frog_X, Frog_Y;
  logic [1:0]  Frog_Dir;
  logic        Frog_Dying;
  logic [2:0]  Lives;
  logic [7:0]  Score;
  logic        Game_Over;

  frog_ctrl dut (
    .frame_clk     (frame_clk),
    .Reset         (Reset),
    .keycode       (keycode),
    .Car_Collision (Car_Collision),
    .Frog_X        (Frog_X),
    .Frog_Y        (Frog_Y),
    .Frog_Dir      (Frog_Dir),
    .Frog_Dying    (Frog_Dying),
    .Lives         (Lives),
    .Score         (Score),
    .Game_Over     (Game_Over)
  );

  always #5 frame_clk = ~frame_clk;

  int n_vec = 0;
  int n_err = 0;

  // behavioural model of the frog
  int         m_x, m_y, m_dir, m_lives, m_score, m_phase;
  int         m_tx, m_ty, m_left, m_die;
  logic [7:0] m_prev;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int dir_of(input logic [7:0] k);
    case (k)
      K_W:     return 0;
      K_S:     return 1;
      K_A:     return 2;
      K_D:     return 3;
      default: return -1;
    endcase
  endfunction

  task automatic model_reset();
    m_x = START_X; m_y = START_Y; m_dir = 0; m_lives = LIVES; m_score = 0;
    m_phase = PH_IDLE; m_prev = K_NONE; m_left = 0; m_die = 0;
  endtask

  task automatic model_step(input logic [7:0] k, input logic c, input logic r);
    int d, tx, ty;
    bit pressed;
    if (r) begin
      model_reset();
      return;
    end
    d = dir_of(k);
    pressed = (d >= 0) && (m_prev != k);
    if ((m_phase == PH_IDLE || m_phase == PH_HOP) && c) begin
      m_lives--;
      if (m_lives == 0) m_phase = PH_OVER;
      else begin m_phase = PH_DIE; m_die = DEATH_LEN; end
    end else if (m_phase == PH_IDLE) begin
      if (pressed) begin
        m_dir = d;
        tx = m_x + ((d == 3) ? STEP : (d == 2) ? -STEP : 0);
        ty = m_y + ((d == 1) ? STEP : (d == 0) ? -STEP : 0);
        if (tx >= 0 && tx <= SCREEN_W - FROG_W && ty >= GOAL_Y && ty <= START_Y) begin
          m_phase = PH_HOP; m_tx = tx; m_ty = ty; m_left = STEP / HOP_PX;
        end
      end
    end else if (m_phase == PH_HOP) begin
      if (m_x < m_tx) m_x += HOP_PX; else if (m_x > m_tx) m_x -= HOP_PX;
      if (m_y < m_ty) m_y += HOP_PX; else if (m_y > m_ty) m_y -= HOP_PX;
      m_left--;
      if (m_left == 0) begin
        m_phase = PH_IDLE;
        if (m_y == GOAL_Y) begin
          if (m_score < 255) m_score++;
          m_x = START_X; m_y = START_Y;
        end
      end
    end else if (m_phase == PH_DIE) begin
      m_die--;
      if (m_die == 0) begin
        m_phase = PH_IDLE; m_x = START_X; m_y = START_Y; m_dir = 0;
      end
    end
    m_prev = k;
  endtask

  // one frame: drive inputs, clock, advance model, compare all outputs
  task automatic frame(input logic [7:0] k, input logic c, input logic r);
    keycode = k; Car_Collision = c; Reset = r;
    @(posedge frame_clk);
    model_step(k, c, r);
    #1;
    check("x",     32'(Frog_X),     32'(m_x));
    check("y",     32'(Frog_Y),     32'(m_y));
    check("dir",   32'(Frog_Dir),   32'(m_dir));
    check("dying", 32'(Frog_Dying), 32'(m_phase == PH_DIE));
    check("lives", 32'(Lives),      32'(m_lives));
    check("score", 32'(Score),      32'(m_score));
    check("over",  32'(Game_Over),  32'(m_phase == PH_OVER));
  endtask

  task automatic hop(input logic [7:0] k);
    frame(k, 1'b0, 1'b0);
    repeat (5) frame(K_NONE, 1'b0, 1'b0);
  endtask

  logic [7:0] key_tab [8];

  initial begin
    key_tab[0] = K_NONE; key_tab[1] = K_W; key_tab[2] = K_W; key_tab[3] = K_A;
    key_tab[4] = K_S;    key_tab[5] = K_D; key_tab[6] = K_SPC; key_tab[7] = K_W;
    model_reset();

    // reset state
    frame(K_NONE, 1'b0, 1'b1);
    frame(K_NONE, 1'b0, 1'b1);
    check("rst_x", 32'(Frog_X), 300);
    check("rst_lives", 32'(Lives), 3);

    // held W: exactly one hop, 8 px per frame
    repeat (3) frame(K_W, 1'b0, 1'b0);
    check("t1_mid_y", 32'(Frog_Y), 424);
    repeat (7) frame(K_W, 1'b0, 1'b0);
    check("t1_y", 32'(Frog_Y), 400);
    check("t1_dir", 32'(Frog_Dir), 0);
    frame(K_NONE, 1'b0, 1'b0);

    // down back to spawn row, then a blocked down press
    hop(K_S);
    hop(K_S);
    check("t1_blk_y", 32'(Frog_Y), 440);
    check("t1_blk_dir", 32'(Frog_Dir), 1);

    // right edge: 580 is the last reachable column, further D only turns
    repeat (7) hop(K_D);
    check("t2_x_edge", 32'(Frog_X), 580);
    hop(K_D);
    check("t2_x_blk", 32'(Frog_X), 580);
    check("t2_dir", 32'(Frog_Dir), 3);
    hop(K_A);
    check("t2_x_left", 32'(Frog_X), 540);

    // full crossing scores and respawns
    repeat (10) hop(K_W);
    check("t3_y40", 32'(Frog_Y), 40);
    hop(K_W);
    check("t3_score", 32'(Score), 1);
    check("t3_x", 32'(Frog_X), 300);
    check("t3_y", 32'(Frog_Y), 440);

    // collision together with a press
    hop(K_D);
    frame(K_W, 1'b1, 1'b0);
    check("t4_lives", 32'(Lives), 2);
    check("t4_dying", 32'(Frog_Dying), 1);
    check("t4_x", 32'(Frog_X), 340);
    repeat (DEATH_LEN) frame(K_NONE, 1'b0, 1'b0);
    check("t4_spawn_x", 32'(Frog_X), 300);
    check("t4_spawn_dying", 32'(Frog_Dying), 0);

    // collision mid-hop freezes the position
    frame(K_W, 1'b0, 1'b0);
    frame(K_NONE, 1'b0, 1'b0);
    frame(K_NONE, 1'b1, 1'b0);
    check("t4b_y", 32'(Frog_Y), 432);
    check("t4b_lives", 32'(Lives), 1);
    repeat (DEATH_LEN) frame(K_NONE, 1'b0, 1'b0);

    // last life: game over is absorbing
    frame(K_NONE, 1'b1, 1'b0);
    check("t5_over", 32'(Game_Over), 1);
    check("t5_lives", 32'(Lives), 0);
    hop(K_W); hop(K_A); hop(K_S); hop(K_D);
    frame(K_NONE, 1'b1, 1'b0);
    check("t5_still_y", 32'(Frog_Y), 440);
    check("t5_still_over", 32'(Game_Over), 1);
    frame(K_NONE, 1'b0, 1'b1);
    check("t5_rst_lives", 32'(Lives), 3);
    check("t5_rst_over", 32'(Game_Over), 0);

    // reset two frames into a hop
    hop(K_W); hop(K_W); hop(K_W); hop(K_W); hop(K_W); hop(K_W);
    hop(K_W); hop(K_W); hop(K_W); hop(K_W); hop(K_W);
    frame(K_W, 1'b0, 1'b0);
    frame(K_NONE, 1'b0, 1'b0);
    frame(K_NONE, 1'b0, 1'b0);
    frame(K_NONE, 1'b0, 1'b1);
    check("t6_y", 32'(Frog_Y), 440);
    check("t6_score", 32'(Score), 0);
    hop(K_W);
    check("t6_hop_y", 32'(Frog_Y), 400);

    // score saturation after 256 crossings
    frame(K_NONE, 1'b0, 1'b1);
    for (int n = 0; n < 256; n++) repeat (11) hop(K_W);
    check("sat_score", 32'(Score), 255);

    // randomized keys, collisions and occasional resets
    frame(K_NONE, 1'b0, 1'b1);
    begin
      logic [7:0] k;
      k = K_NONE;
      for (int i = 0; i < 4000; i++) begin
        if ($urandom_range(0, 2) == 0) k = key_tab[$urandom_range(0, 7)];
        frame(k, ($urandom_range(0, 39) == 0), ($urandom_range(0, 299) == 0));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
